// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA horizontal/vertical timing generator gated by a pixel-clock enable.
// Define VGA_TIMING_FRAME_CNT_EN to build the 16-bit completed-frame counter; otherwise frame_cnt reads 0.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic        HS_POL   = 1'b0,
  parameter logic        VS_POL   = 1'b0,
  parameter int unsigned CW       = 10
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          pix_en,
  input  logic          soft_clr,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          done_x,
  output logic          done_y,
  output logic          frame_end,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic [15:0]   frame_cnt
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

  if ((64'd1 << CW) < 64'(H_TOTAL) || (64'd1 << CW) < 64'(V_TOTAL)) begin : g_bad_width
    $error("vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
  end
  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_timing
    $error("vga_timing_gen: timing parameters must be non-zero");
  end

  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          video_on_q, video_on_d;

  assign done_x    = (x_q == H_LAST);
  assign done_y    = (y_q == V_LAST);
  assign frame_end = done_x & done_y & pix_en;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (soft_clr) begin
      x_d = '0;
      y_d = '0;
    end else if (pix_en) begin
      if (done_x) begin
        x_d = '0;
        y_d = done_y ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  // Decoding the next-state counters keeps the registered syncs aligned with pixel_x/pixel_y.
  always_comb begin
    hsync_d    = ((x_d >= HS_FIRST) && (x_d <= HS_LAST)) ? HS_POL : ~HS_POL;
    vsync_d    = ((y_d >= VS_FIRST) && (y_d <= VS_LAST)) ? VS_POL : ~VS_POL;
    video_on_d = (x_d < H_VIS) && (y_d < V_VIS);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q        <= '0;
      y_q        <= '0;
      hsync_q    <= ~HS_POL;
      vsync_q    <= ~VS_POL;
      video_on_q <= 1'b1;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      video_on_q <= video_on_d;
    end
  end

  assign pixel_x  = x_q;
  assign pixel_y  = y_q;
  assign hsync    = hsync_q;
  assign vsync    = vsync_q;
  assign video_on = video_on_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  // A soft clear on the final pixel abandons the frame, so it is not counted.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_end && !soft_clr) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_q <= 16'd0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = 16'h0000;
`endif

endmodule
